// File: rtl/exp_acc_scheduler.sv
// exp_acc_scheduler
// Round-robin scheduler that shares one exponential-accumulator engine and its
// 21-bit result FIFO among four requesters. The winner's operands are latched,
// the engine is started, completion is awaited under a watchdog, the FIFO is
// drained with each word tagged by the owner's index, and a one-cycle done
// (with err on timeout) is returned to the owner.
module exp_acc_scheduler #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [63:0] vi_bus,
    input  logic [7:0]  ui_bus,
    output logic [3:0]  gnt,
    output logic [3:0]  done_o,
    output logic        err_o,
    output logic [15:0] eng_vi,
    output logic [1:0]  eng_ui,
    output logic        eng_start,
    input  logic        eng_done,
    input  logic        fifo_empty,
    input  logic [20:0] fifo_q,
    output logic        rd_req,
    output logic        res_valid,
    output logic [20:0] res_data,
    output logic [1:0]  res_id
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    // Watchdog terminal count: WAIT lasts exactly TIMEOUT cycles.
    localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

    state_t      state;
    logic [1:0]  last;      // requester served most recently
    logic [1:0]  id;        // requester owning the current run
    logic [9:0]  wd_cnt;    // watchdog counter, cleared in START
    logic        rd_q;      // rd_req delayed to match FIFO read latency

    logic [1:0]  win_id;
    logic        win_any;
    logic [1:0]  cand;

    // Round-robin search: last+1, last+2, last+3, then last itself
    always_comb begin
        win_id  = last;
        win_any = 1'b0;
        cand    = last;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last + 2'(i);
            if (!win_any && req[cand]) begin
                win_id  = cand;
                win_any = 1'b1;
            end
        end
    end

    // FIFO read is issued only while draining and the FIFO still holds data
    always_comb begin
        rd_req    = (state == S_DRAIN) && !fifo_empty;
        res_valid = rd_q;
        res_data  = fifo_q;
        res_id    = id;
    end

    // Scheduler FSM with registered grant, start, done and error outputs.
    // err_o doubles as the error flag: it is only ever set on the transition
    // into DONE and cleared on the way out, so a separate flag would mirror it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            last      <= 2'd3;
            id        <= '0;
            wd_cnt    <= '0;
            rd_q      <= 1'b0;
            gnt       <= '0;
            done_o    <= '0;
            err_o     <= 1'b0;
            eng_vi    <= '0;
            eng_ui    <= '0;
            eng_start <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            done_o    <= '0;
            rd_q      <= rd_req;
            unique case (state)
                S_IDLE: begin
                    err_o <= 1'b0;
                    if (win_any) begin
                        id        <= win_id;
                        gnt       <= 4'b0001 << win_id;
                        eng_vi    <= vi_bus[{win_id, 4'b0000} +: 16];
                        eng_ui    <= ui_bus[{win_id, 1'b0} +: 2];
                        eng_start <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    wd_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        state <= S_DRAIN;
                    end else if (wd_cnt == WD_LAST) begin
                        err_o  <= 1'b1;
                        done_o <= 4'b0001 << id;
                        state  <= S_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 10'd1;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        done_o <= 4'b0001 << id;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    last  <= id;
                    gnt   <= '0;
                    err_o <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    gnt   <= '0;
                    err_o <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp_acc_scheduler.sv
// tb_exp_acc_scheduler
// Self-checking bench: drives the scheduler with an engine/FIFO model and
// compares each run against a transaction-level round-robin reference.
module tb_exp_acc_scheduler;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] vi_bus;
    logic [7:0]  ui_bus;
    logic [3:0]  gnt;
    logic [3:0]  done_o;
    logic        err_o;
    logic [15:0] eng_vi;
    logic [1:0]  eng_ui;
    logic        eng_start;
    logic        eng_done;
    logic        fifo_empty;
    logic [20:0] fifo_q;
    logic        rd_req;
    logic        res_valid;
    logic [20:0] res_data;
    logic [1:0]  res_id;

    exp_acc_scheduler #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .vi_bus     (vi_bus),
        .ui_bus     (ui_bus),
        .gnt        (gnt),
        .done_o     (done_o),
        .err_o      (err_o),
        .eng_vi     (eng_vi),
        .eng_ui     (eng_ui),
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .rd_req     (rd_req),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int m_last = 3;

    // engine / FIFO model state
    logic [20:0] fifo_mem[$];
    logic [20:0] pushed[$];
    int          eng_at  = -1;
    int          eng_k   = 0;
    logic        rd_seen = 1'b0;

    // observations of the latest run
    logic [3:0]  o_gnt, o_done_v, o_gnt_after;
    logic [15:0] o_vi, o_vi_done;
    logic [1:0]  o_ui;
    logic        o_start, o_err;
    int          o_start_cnt, o_rd_cnt, o_gnt_bad, o_err_stray, o_done_rel;
    logic [20:0] o_words[$];
    logic [1:0]  o_rids[$];

    // reference: first requester in order last+1 .. last+4 with req set
    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int j = 1; j <= 4; j++)
            if (r[(last + j) % 4]) return (last + j) % 4;
        return -1;
    endfunction

    // reference: cycles from eng_start to done_o. Engine done at M, k reads
    // M+1..M+k, empty first seen at M+k+1, DONE one cycle later.
    // Timeout: TO cycles of WAIT, then DONE.
    function automatic int exp_done_rel(input int dly, input int k);
        return (dly > TO) ? TO + 1 : dly + k + 2;
    endfunction

    function automatic int word_errs(input int eid);
        int bad = 0;
        if (o_words.size() != pushed.size()) bad++;
        foreach (o_words[i]) begin
            if (i >= pushed.size() || o_words[i] !== pushed[i]) bad++;
            if (o_rids[i] !== 2'(eid)) bad++;
        end
        return bad;
    endfunction

    // one clock: update engine/FIFO inputs after the edge, sample at negedge
    task automatic tick();
        logic [20:0] w;
        @(posedge clk);
        #1;
        cyc++;
        if (rd_seen && fifo_mem.size() > 0) fifo_q = fifo_mem.pop_front();
        eng_done = (cyc == eng_at);
        if (cyc == eng_at) begin
            for (int i = 0; i < eng_k; i++) begin
                w = 21'($urandom);
                fifo_mem.push_back(w);
                pushed.push_back(w);
            end
        end
        fifo_empty = (fifo_mem.size() == 0);
        @(negedge clk);
        rd_seen = rd_req;
    endtask

    task automatic apply_reset();
        #2 rst = 1'b1;
        req = '0;
        eng_done = 1'b0;
        eng_at = -1;
        fifo_mem.delete();
        fifo_empty = 1'b1;
        rd_seen = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_last = 3;
    endtask

    // one scheduled run; starts at a negedge with the DUT idle
    task automatic run_txn(input logic [3:0] r, input logic [63:0] vb, input logic [7:0] ub,
                           input int dly, input int k, input int abort_words, input bit hold_req);
        int start;
        int limit;
        req = r;
        vi_bus = vb;
        ui_bus = ub;
        pushed.delete();
        o_words.delete();
        o_rids.delete();
        o_start_cnt = 0; o_rd_cnt = 0; o_gnt_bad = 0; o_err_stray = 0;
        o_done_rel = -1; o_done_v = '0; o_err = 1'b0; o_vi_done = '0;
        tick();
        start = cyc;
        o_gnt = gnt; o_vi = eng_vi; o_ui = eng_ui; o_start = eng_start;
        vi_bus = {$urandom, $urandom};
        ui_bus = 8'($urandom);
        if (!hold_req) req = 4'($urandom);
        eng_at = start + dly;
        eng_k = k;
        limit = start + TO + k + 12;
        while (o_done_rel < 0 && cyc < limit) begin
            tick();
            if (eng_start) o_start_cnt++;
            if (rd_req) o_rd_cnt++;
            if (gnt !== o_gnt) o_gnt_bad++;
            if (err_o && !(|done_o)) o_err_stray++;
            if (res_valid) begin
                o_words.push_back(res_data);
                o_rids.push_back(res_id);
            end
            if (|done_o) begin
                o_done_rel = cyc - start;
                o_done_v = done_o;
                o_err = err_o;
                o_vi_done = eng_vi;
            end
            if (abort_words > 0 && o_words.size() >= abort_words) return;
        end
        eng_done = 1'b0;
        eng_at = -1;
        tick();
        o_gnt_after = gnt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0; vi_bus = '0; ui_bus = '0;
        eng_done = 1'b0; fifo_empty = 1'b1; fifo_q = '0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if ({gnt, done_o, err_o, eng_vi, eng_ui, eng_start, rd_req, res_valid, res_id} !== '0) begin
            $display("FAIL reset_outputs: gnt=%b done=%b err=%b vi=%h ui=%b start=%b rd=%b rv=%b id=%0d, want all 0",
                     gnt, done_o, err_o, eng_vi, eng_ui, eng_start, rd_req, res_valid, res_id);
            n_err++;
        end
        rst = 1'b0;
        m_last = 3;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (gnt !== '0 || eng_start !== 1'b0) begin
                $display("FAIL idle_no_req: gnt=%b start=%b, want 0", gnt, eng_start);
                n_err++;
            end
        end
    endtask

    task automatic test_single();
        int eid = rr_pick(4'b0001, m_last);
        run_txn(4'b0001, {48'h0, 16'h0003}, 8'b0000_0001, 10, 2, 0, 1'b0);
        n_vec++;
        if (o_gnt !== 4'b0001 || o_start !== 1'b1 || o_start_cnt != 0) begin
            $display("FAIL single_start: gnt=%b start=%b extra=%0d, want 0001/1/0", o_gnt, o_start, o_start_cnt);
            n_err++;
        end
        n_vec++;
        if (o_vi !== 16'h0003 || o_ui !== 2'b01) begin
            $display("FAIL single_operands: vi=%h ui=%b, want 0003/01", o_vi, o_ui);
            n_err++;
        end
        n_vec++;
        if (word_errs(eid) != 0 || o_words.size() != 2) begin
            $display("FAIL single_words: got %0d words, want 2 in FIFO order with id %0d", o_words.size(), eid);
            n_err++;
        end
        n_vec++;
        if (o_done_v !== 4'b0001 || o_err !== 1'b0 || o_done_rel != exp_done_rel(10, 2)) begin
            $display("FAIL single_done: done=%b err=%b at +%0d, want 0001/0 at +%0d",
                     o_done_v, o_err, o_done_rel, exp_done_rel(10, 2));
            n_err++;
        end
        m_last = eid;
    endtask

    task automatic test_fairness();
        int seq[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            run_txn(4'b1111, {$urandom, $urandom}, 8'($urandom), $urandom_range(1, 5), 1, 0, 1'b1);
            n_vec++;
            if (o_gnt !== 4'(1 << seq[i]) || o_done_v !== 4'(1 << seq[i])) begin
                $display("FAIL fairness_%0d: gnt=%b done=%b, want onehot(%0d)", i, o_gnt, o_done_v, seq[i]);
                n_err++;
            end
            m_last = seq[i];
        end
    endtask

    task automatic test_zero();
        int dly = $urandom_range(1, 6);
        logic [3:0] r = 4'($urandom_range(1, 15));
        int eid = rr_pick(r, m_last);
        run_txn(r, {$urandom, $urandom}, 8'($urandom), dly, 0, 0, 1'b0);
        n_vec++;
        if (o_rd_cnt != 0 || o_words.size() != 0) begin
            $display("FAIL zero_reads: rd=%0d words=%0d, want 0/0", o_rd_cnt, o_words.size());
            n_err++;
        end
        n_vec++;
        if (o_done_rel != dly + 2 || o_done_v !== 4'(1 << eid) || o_err !== 1'b0) begin
            $display("FAIL zero_done: done=%b err=%b at +%0d, want onehot(%0d)/0 at +%0d",
                     o_done_v, o_err, o_done_rel, eid, dly + 2);
            n_err++;
        end
        m_last = eid;
    endtask

    task automatic test_timeout();
        logic [3:0] r = 4'($urandom_range(1, 15));
        int eid = rr_pick(r, m_last);
        run_txn(r, {$urandom, $urandom}, 8'($urandom), 1000, 2, 0, 1'b0);
        n_vec++;
        if (o_done_rel != TO + 1 || o_done_v !== 4'(1 << eid) || o_err !== 1'b1) begin
            $display("FAIL timeout_done: done=%b err=%b at +%0d, want onehot(%0d)/1 at +%0d",
                     o_done_v, o_err, o_done_rel, eid, TO + 1);
            n_err++;
        end
        n_vec++;
        if (o_rd_cnt != 0 || o_err_stray != 0 || o_gnt_after !== '0) begin
            $display("FAIL timeout_side: rd=%0d stray_err=%0d gnt_after=%b, want 0/0/0",
                     o_rd_cnt, o_err_stray, o_gnt_after);
            n_err++;
        end
        m_last = eid;
        eid = rr_pick(4'b1111, m_last);
        run_txn(4'b1111, {$urandom, $urandom}, 8'($urandom), 4, 2, 0, 1'b0);
        n_vec++;
        if (o_gnt !== 4'(1 << eid) || o_err !== 1'b0 || word_errs(eid) != 0 || o_done_rel != exp_done_rel(4, 2)) begin
            $display("FAIL after_timeout: gnt=%b err=%b words=%0d at +%0d, want onehot(%0d)/0/2 at +%0d",
                     o_gnt, o_err, o_words.size(), o_done_rel, eid, exp_done_rel(4, 2));
            n_err++;
        end
        m_last = eid;
    endtask

    task automatic test_simultaneous();
        int k = $urandom_range(1, 3);
        logic [3:0] r = 4'($urandom_range(1, 15));
        int eid = rr_pick(r, m_last);
        run_txn(r, {$urandom, $urandom}, 8'($urandom), TO, k, 0, 1'b0);
        n_vec++;
        if (o_err !== 1'b0 || o_done_rel != exp_done_rel(TO, k)) begin
            $display("FAIL simul_done: err=%b at +%0d, want 0 at +%0d", o_err, o_done_rel, exp_done_rel(TO, k));
            n_err++;
        end
        n_vec++;
        if (word_errs(eid) != 0 || o_rd_cnt != k) begin
            $display("FAIL simul_drain: words=%0d rd=%0d, want %0d/%0d", o_words.size(), o_rd_cnt, k, k);
            n_err++;
        end
        m_last = eid;
    endtask

    task automatic test_async_reset();
        run_txn(4'b0001, {$urandom, $urandom}, 8'($urandom), 2, 1, 0, 1'b0);
        m_last = 0;
        run_txn(4'b0001, {$urandom, $urandom}, 8'($urandom), 3, 3, 1, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({gnt, done_o, err_o, eng_vi, eng_ui, eng_start, rd_req, res_valid, res_id} !== '0) begin
            $display("FAIL async_reset: gnt=%b done=%b err=%b vi=%h ui=%b start=%b rd=%b rv=%b id=%0d, want all 0",
                     gnt, done_o, err_o, eng_vi, eng_ui, eng_start, rd_req, res_valid, res_id);
            n_err++;
        end
        req = '0;
        eng_done = 1'b0;
        eng_at = -1;
        fifo_mem.delete();
        fifo_empty = 1'b1;
        rd_seen = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_last = 3;
        run_txn(4'b1001, {$urandom, $urandom}, 8'($urandom), 2, 1, 0, 1'b0);
        n_vec++;
        if (o_gnt !== 4'b0001 || o_done_v !== 4'b0001) begin
            $display("FAIL post_reset_grant: gnt=%b done=%b, want 0001/0001", o_gnt, o_done_v);
            n_err++;
        end
        m_last = 0;
    endtask

    task automatic test_random();
        logic [3:0]  r;
        logic [63:0] vb;
        logic [7:0]  ub;
        int dly, k, eid;
        for (int n = 0; n < 24; n++) begin
            r   = 4'($urandom_range(1, 15));
            dly = ($urandom_range(0, 4) == 0) ? 1000 : $urandom_range(1, TO);
            k   = $urandom_range(0, 4);
            vb  = {$urandom, $urandom};
            ub  = 8'($urandom);
            eid = rr_pick(r, m_last);
            run_txn(r, vb, ub, dly, k, 0, 1'($urandom_range(0, 1)));
            n_vec++;
            if (o_gnt !== 4'(1 << eid) || o_start !== 1'b1 || o_start_cnt != 0) begin
                $display("FAIL rand%0d_grant: gnt=%b start=%b extra=%0d, want onehot(%0d)/1/0",
                         n, o_gnt, o_start, o_start_cnt, eid);
                n_err++;
            end
            n_vec++;
            if (o_vi !== vb[16*eid +: 16] || o_ui !== ub[2*eid +: 2] || o_vi_done !== vb[16*eid +: 16]) begin
                $display("FAIL rand%0d_operands: vi=%h ui=%b vi_at_done=%h, want %h/%b",
                         n, o_vi, o_ui, o_vi_done, vb[16*eid +: 16], ub[2*eid +: 2]);
                n_err++;
            end
            n_vec++;
            if (o_done_rel != exp_done_rel(dly, k) || o_done_v !== 4'(1 << eid) || o_err !== (dly > TO)) begin
                $display("FAIL rand%0d_done: done=%b err=%b at +%0d, want onehot(%0d)/%0d at +%0d",
                         n, o_done_v, o_err, o_done_rel, eid, dly > TO, exp_done_rel(dly, k));
                n_err++;
            end
            n_vec++;
            if (word_errs(eid) != 0 || o_rd_cnt != ((dly > TO) ? 0 : k)) begin
                $display("FAIL rand%0d_results: words=%0d rd=%0d, want %0d", n, o_words.size(), o_rd_cnt, pushed.size());
                n_err++;
            end
            n_vec++;
            if (o_gnt_bad != 0 || o_gnt_after !== '0 || o_err_stray != 0) begin
                $display("FAIL rand%0d_gnt_hold: glitches=%0d after=%b stray_err=%0d, want 0/0000/0",
                         n, o_gnt_bad, o_gnt_after, o_err_stray);
                n_err++;
            end
            m_last = eid;
            req = '0;
            repeat ($urandom_range(0, 2)) begin
                tick();
                n_vec++;
                if (gnt !== '0) begin
                    $display("FAIL rand%0d_gap: gnt=%b, want 0000", n, gnt);
                    n_err++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_zero();
        test_timeout();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
